vendor_ctrl: RTL and testbench
==============================

# vendor_ctrl

Parametrised vending controller, the next generation of the three-drink vendor. It supports NUM_ITEMS products with a price table, per-item stock counters, coin overflow rejection and an optional payment timeout. Change and refunds are paid out as a sequential stream of 1 yuan / 5 jiao / 1 jiao coin pulses instead of a static count. It sits between the pulse-conditioned switch inputs (one-cycle pulses from the edge detectors) and the 7-segment/LED display logic.

## Interface
- NUM_ITEMS, 4: number of selectable products (1..16).
- MW, 7: money width in jiao; totals saturate-checked against 2^MW-1.
- PRICE_TABLE, {7'd25,7'd20,7'd14,7'd10}: flattened NUM_ITEMS*MW prices in jiao; item i at bits [i*MW +: MW]; each price must be nonzero.
- SW_W, 4: stock counter width.
- INIT_STOCK, 5: stock per item at reset/restock.
- TIMEOUT_CYCLES, 500_000_000: cycles without a coin in PAY before auto-refund.
- CLOCK_50  in  1  clock.
- KEY  in  1  asynchronous active-low reset.
- sel  in  NUM_ITEMS  one-cycle product-select pulses.
- coin_in  in  3  one-cycle coin pulses: [0]=1 jiao, [1]=5 jiao, [2]=10 jiao.
- confirm  in  1  level; purchase confirm.
- cancel  in  1  level; cancel purchase.
- restock  in  1  one-cycle pulse; reload all stock counters.
- state  out  3  current state code.
- price  out  MW  selected item price.
- total  out  MW  money inserted.
- change_left  out  MW  money still owed to customer.
- item_out  out  NUM_ITEMS  one-cycle vend pulse, one-hot.
- coin_out  out  3  one-cycle change pulses, same bit mapping as coin_in.
- coin_reject  out  1  one-cycle pulse: inserted coin(s) returned.
- sold_out  out  NUM_ITEMS  level; item stock is 0.
- pay_ok  out  1  level; state is READY.

## Operation
- State codes: IDLE=1, PAY=2, READY=3, VEND=4, REFUND=5, CHANGE=6. Unused codes go to IDLE.
- IDLE:
  - total=0, change_left=0.
  - A sel pulse on an in-stock item latches price and item index and moves to PAY. Simultaneous sel pulses: lowest index wins.
  - sel on a sold-out item is ignored.
  - restock reloads all counters to INIT_STOCK; restock is ignored in other states.
- PAY/READY coin handling:
  - All coin_in bits asserted in a cycle are summed (1+5+10 = 16 max).
  - If total+sum > 2^MW-1, the whole sum is rejected: coin_reject pulses and total is unchanged.
  - Otherwise total += sum.
  - Coins in any other state are rejected.
- PAY transitions:
  - cancel -> REFUND; takes priority over everything.
  - Otherwise, if total (including this cycle's accepted coins) >= price -> READY.
- READY: coins are still accepted. Priority: cancel -> REFUND, then confirm -> VEND.
- VEND:
  - One cycle.
  - item_out[idx] pulses and stock[idx] decrements; stock never wraps below 0.
  - change_left = total - price.
  - Next state is CHANGE.
- REFUND: one cycle; change_left = total; next state is CHANGE.
- CHANGE:
  - One coin per cycle, greedy: coin_out[2] if change_left >= 10, else coin_out[1] if >= 5, else coin_out[0].
  - change_left decrements by the coin value.
  - When change_left = 0 at entry or after a payout, go to IDLE and clear total/price.
- sold_out[i] = (stock[i]==0), from registered stock.
- Reset (any time, including mid-CHANGE):
  - State IDLE.
  - price, total and change_left are 0.
  - item_out, coin_out and coin_reject are 0.
  - Stock is INIT_STOCK.
  - A partial payout is abandoned.

## Timing
- All outputs are registered.
- sel in cycle n gives state=PAY at n+1.
- A coin in cycle n appears in total at n+1. If that reaches price, READY at n+1.
- confirm sampled in READY at n gives VEND at n+1 with item_out high during n+1, then CHANGE at n+2.
- First coin_out pulse at n+2.
- Change of C jiao completes in floor(C/10) + floor(C%10/5) + C%5 CHANGE cycles.
- coin_reject is asserted in the cycle after the rejected coin_in.

## Configuration
- VENDOR_TIMEOUT_EN defined:
  - A counter resets on state entry to PAY and on every accepted coin.
  - Reaching TIMEOUT_CYCLES in PAY forces REFUND. A timeout with total=0 still goes REFUND -> CHANGE -> IDLE.
  - READY never times out.
- VENDOR_TIMEOUT_EN undefined: no counter is implemented, and PAY waits indefinitely.

## Test plan
- Select item 1 (price 14), insert 10 then 5, confirm: READY after the 5; item_out=0010; change_left=1; one coin_out[0] pulse; stock[1] 5->4; back to IDLE.
- Select item 0 (price 10), insert 5 and 1, then cancel: REFUND; coin_out sequence [1] then [0]; total returns to 0; no item_out.
- Buy item 3 five times: sold_out[3]=1; a further sel[3] leaves state=IDLE; restock clears sold_out.
- Select item 3 (price 25), insert 10 pulses nine times with MW=7: the 13th... totals 90; inserting coins to 126 then a 10-jiao coin gives coin_reject=1 and total stays 126; confirm -> change 101 paid as ten 10s then one 1.
- With VENDOR_TIMEOUT_EN and TIMEOUT_CYCLES=20: select, insert 5, idle 20 cycles -> REFUND, single coin_out[1].
- Assert KEY low during CHANGE with change_left=15: all outputs 0, state=1, stock restored to INIT_STOCK.

Source files
------------

// File: rtl/vendor_ctrl.sv
// vendor_ctrl: parametrised NUM_ITEMS-product vending controller.
// It keeps a price table and a stock counter for each item, and rejects coins
// that would overflow the MW-bit total. Change and refunds are paid out as a
// stream of single coins, one per cycle: 10 jiao, 5 jiao or 1 jiao.
// Optional feature: define VENDOR_TIMEOUT_EN to auto-refund when PAY has seen
// no accepted coin for TIMEOUT_CYCLES cycles.
module vendor_ctrl #(
    parameter int                      NUM_ITEMS      = 4,
    parameter int                      MW             = 7,
    parameter logic [NUM_ITEMS*MW-1:0] PRICE_TABLE    = {7'd25, 7'd20, 7'd14, 7'd10},
    parameter int                      SW_W           = 4,
    parameter int                      INIT_STOCK     = 5,
    parameter int                      TIMEOUT_CYCLES = 500_000_000
) (
    input  logic                 CLOCK_50,
    input  logic                 KEY,
    input  logic [NUM_ITEMS-1:0] sel,
    input  logic [2:0]           coin_in,
    input  logic                 confirm,
    input  logic                 cancel,
    input  logic                 restock,
    output logic [2:0]           state,
    output logic [MW-1:0]        price,
    output logic [MW-1:0]        total,
    output logic [MW-1:0]        change_left,
    output logic [NUM_ITEMS-1:0] item_out,
    output logic [2:0]           coin_out,
    output logic                 coin_reject,
    output logic [NUM_ITEMS-1:0] sold_out,
    output logic                 pay_ok
);
    localparam int IW = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
    // Extra headroom so that total + 16 can be compared without wrapping.
    localparam int XW = MW + 5;
    localparam logic [XW-1:0] MAX_TOTAL = XW'((1 << MW) - 1);

    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_PAY    = 3'd2;
    localparam logic [2:0] S_READY  = 3'd3;
    localparam logic [2:0] S_VEND   = 3'd4;
    localparam logic [2:0] S_REFUND = 3'd5;
    localparam logic [2:0] S_CHANGE = 3'd6;

    logic [2:0]           r_state;
    logic [MW-1:0]        r_price;
    logic [MW-1:0]        r_total;
    logic [MW-1:0]        r_change_left;
    logic [IW-1:0]        r_idx;
    logic [NUM_ITEMS-1:0] r_item_out;
    logic [2:0]           r_coin_out;
    logic                 r_coin_reject;
    logic                 r_pay_ok;

    logic [MW-1:0]        w_price_tab [NUM_ITEMS];
    logic [NUM_ITEMS-1:0] w_in_stock;
    logic [4:0]           w_coin_sum;
    logic [XW-1:0]        w_total_sum;
    logic                 w_coin_state;
    logic                 w_overflow;
    logic                 w_coin_accept;
    logic                 w_coin_reject;
    logic [MW-1:0]        w_total_acc;
    logic                 w_sel_hit;
    logic [IW-1:0]        w_sel_idx;
    logic [2:0]           w_pay_coin;
    logic [MW-1:0]        w_pay_val;
    logic                 w_timeout;
    logic                 w_restock;
    logic                 w_vend;

    logic [2:0]           w_state_next;
    logic [MW-1:0]        w_price_next;
    logic [MW-1:0]        w_total_next;
    logic [MW-1:0]        w_change_next;
    logic [IW-1:0]        w_idx_next;
    logic [NUM_ITEMS-1:0] w_item_next;
    logic [2:0]           w_coin_out_next;

    assign w_restock = (r_state == S_IDLE) && restock;

    // Per-item price lookup, stock counter and sold-out flag.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_ITEMS; gi++) begin : g_item
            logic [SW_W-1:0] r_stock;

            assign w_price_tab[gi] = PRICE_TABLE[gi*MW +: MW];
            assign w_in_stock[gi]  = (r_stock != '0);
            assign sold_out[gi]    = ~w_in_stock[gi];

            // Stock: reload on restock in IDLE, decrement when this item vends.
            always_ff @(posedge CLOCK_50 or negedge KEY) begin
                if (!KEY) begin
                    r_stock <= SW_W'(INIT_STOCK);
                end else if (w_restock) begin
                    r_stock <= SW_W'(INIT_STOCK);
                end else if (w_vend && (r_idx == IW'(gi)) && (r_stock != '0)) begin
                    r_stock <= r_stock - 1'b1;
                end
            end
        end
    endgenerate

    // Coin acceptance: coins are summed, and the whole sum is rejected on overflow or outside PAY/READY.
    assign w_coin_sum    = (coin_in[0] ? 5'd1 : 5'd0) + (coin_in[1] ? 5'd5 : 5'd0)
                         + (coin_in[2] ? 5'd10 : 5'd0);
    assign w_total_sum   = XW'(r_total) + XW'(w_coin_sum);
    assign w_coin_state  = (r_state == S_PAY) || (r_state == S_READY);
    assign w_overflow    = (w_total_sum > MAX_TOTAL);
    assign w_coin_accept = w_coin_state && (|coin_in) && !w_overflow;
    assign w_coin_reject = (|coin_in) && (!w_coin_state || w_overflow);
    assign w_total_acc   = w_coin_accept ? w_total_sum[MW-1:0] : r_total;

    // Product select: the lowest-index in-stock pulse wins.
    always_comb begin
        w_sel_hit = 1'b0;
        w_sel_idx = '0;
        for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
            if (sel[i] && w_in_stock[i]) begin
                w_sel_hit = 1'b1;
                w_sel_idx = IW'(i);
            end
        end
    end

    // Greedy payout: pick the largest coin that does not exceed the amount still owed.
    always_comb begin
        w_pay_coin = 3'b000;
        w_pay_val  = '0;
        if (XW'(r_change_left) >= XW'(10)) begin
            w_pay_coin = 3'b100;
            w_pay_val  = MW'(10);
        end else if (XW'(r_change_left) >= XW'(5)) begin
            w_pay_coin = 3'b010;
            w_pay_val  = MW'(5);
        end else if (r_change_left != '0) begin
            w_pay_coin = 3'b001;
            w_pay_val  = MW'(1);
        end
    end

`ifdef VENDOR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_to_cnt;

    // Idle-time counter: held at 0 outside PAY, cleared by every accepted coin.
    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            r_to_cnt <= '0;
        end else if ((r_state != S_PAY) || w_coin_accept) begin
            r_to_cnt <= '0;
        end else if (!w_timeout) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_PAY) && !w_coin_accept
                     && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    // No timeout hardware. This folds to 0 for any legal TIMEOUT_CYCLES.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    // Next-state and datapath decisions for the vending sequence.
    always_comb begin
        w_state_next    = r_state;
        w_price_next    = r_price;
        w_total_next    = r_total;
        w_change_next   = r_change_left;
        w_idx_next      = r_idx;
        w_item_next     = '0;
        w_coin_out_next = 3'b000;
        w_vend          = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_total_next  = '0;
                w_change_next = '0;
                if (w_sel_hit) begin
                    w_state_next = S_PAY;
                    w_price_next = w_price_tab[w_sel_idx];
                    w_idx_next   = w_sel_idx;
                end
            end
            S_PAY: begin
                w_total_next = w_total_acc;
                if (cancel || w_timeout) begin
                    w_state_next  = S_REFUND;
                    w_change_next = w_total_acc;
                end else if (w_total_acc >= r_price) begin
                    w_state_next = S_READY;
                end
            end
            S_READY: begin
                w_total_next = w_total_acc;
                if (cancel) begin
                    w_state_next  = S_REFUND;
                    w_change_next = w_total_acc;
                end else if (confirm) begin
                    w_state_next       = S_VEND;
                    w_change_next      = w_total_acc - r_price;
                    w_item_next[r_idx] = 1'b1;
                    w_vend             = 1'b1;
                end
            end
            S_VEND, S_REFUND: begin
                w_state_next    = S_CHANGE;
                w_coin_out_next = w_pay_coin;
                w_change_next   = r_change_left - w_pay_val;
            end
            S_CHANGE: begin
                if (r_change_left == '0) begin
                    w_state_next = S_IDLE;
                    w_total_next = '0;
                    w_price_next = '0;
                end else begin
                    w_coin_out_next = w_pay_coin;
                    w_change_next   = r_change_left - w_pay_val;
                end
            end
            default: begin
                w_state_next  = S_IDLE;
                w_total_next  = '0;
                w_price_next  = '0;
                w_change_next = '0;
            end
        endcase
    end

    // Registered state and outputs.
    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            r_state       <= S_IDLE;
            r_price       <= '0;
            r_total       <= '0;
            r_change_left <= '0;
            r_idx         <= '0;
            r_item_out    <= '0;
            r_coin_out    <= 3'b000;
            r_coin_reject <= 1'b0;
            r_pay_ok      <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_price       <= w_price_next;
            r_total       <= w_total_next;
            r_change_left <= w_change_next;
            r_idx         <= w_idx_next;
            r_item_out    <= w_item_next;
            r_coin_out    <= w_coin_out_next;
            r_coin_reject <= w_coin_reject;
            r_pay_ok      <= (w_state_next == S_READY);
        end
    end

    assign state       = r_state;
    assign price       = r_price;
    assign total       = r_total;
    assign change_left = r_change_left;
    assign item_out    = r_item_out;
    assign coin_out    = r_coin_out;
    assign coin_reject = r_coin_reject;
    assign pay_ok      = r_pay_ok;

endmodule

// File: tb/tb_vendor_ctrl.sv
// tb_vendor_ctrl: vector table, hand-written corner sequences and a random
// phase. Every phase is checked cycle by cycle against a behavioural model.
module tb_vendor_ctrl;
    logic       clk = 1'b0;
    logic       KEY = 1'b0;
    logic [3:0] sel = '0;
    logic [2:0] coin_in = '0;
    logic       confirm = 1'b0, cancel = 1'b0, restock = 1'b0;
    logic [2:0] state;
    logic [6:0] price, total, change_left;
    logic [3:0] item_out;
    logic [2:0] coin_out;
    logic       coin_reject;
    logic [3:0] sold_out;
    logic       pay_ok;

    always #5 clk = ~clk;

    vendor_ctrl #(
        .NUM_ITEMS(4), .MW(7), .PRICE_TABLE({7'd25, 7'd20, 7'd14, 7'd10}),
        .SW_W(4), .INIT_STOCK(5), .TIMEOUT_CYCLES(20)
    ) dut (
        .CLOCK_50(clk), .KEY(KEY), .sel(sel), .coin_in(coin_in),
        .confirm(confirm), .cancel(cancel), .restock(restock),
        .state(state), .price(price), .total(total), .change_left(change_left),
        .item_out(item_out), .coin_out(coin_out), .coin_reject(coin_reject),
        .sold_out(sold_out), .pay_ok(pay_ok)
    );

`ifdef VENDOR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int prices [4] = '{10, 14, 20, 25};

    // Behavioural model: the amount owed becomes a queue of coins when a payout starts.
    int         m_state, m_price, m_total, m_cl, m_idx, m_idle;
    int         m_stock [4];
    logic [3:0] m_item;
    logic [2:0] m_coin;
    logic       m_rej;
    int         m_pay [$];

    function automatic void model_reset();
        m_state = 1; m_price = 0; m_total = 0; m_cl = 0; m_idx = 0; m_idle = 0;
        for (int i = 0; i < 4; i++) m_stock[i] = 5;
        m_item = '0; m_coin = '0; m_rej = 1'b0;
        m_pay.delete();
    endfunction

    function automatic void start_pay(input int amt);
        m_cl = amt;
        m_pay.delete();
        repeat (amt / 10) m_pay.push_back(10);
        repeat ((amt % 10) / 5) m_pay.push_back(5);
        repeat (amt % 5) m_pay.push_back(1);
    endfunction

    function automatic void pay_one();
        int v;
        v = m_pay.pop_front();
        m_coin = (v == 10) ? 3'b100 : (v == 5) ? 3'b010 : 3'b001;
        m_cl = m_cl - v;
    endfunction

    function automatic void model_step(input logic [3:0] s, input logic [2:0] c,
                                       input logic cf, input logic cn, input logic rs);
        int sum, nt, pick;
        bit paying, acc;
        sum    = (c[0] ? 1 : 0) + (c[1] ? 5 : 0) + (c[2] ? 10 : 0);
        paying = (m_state == 2) || (m_state == 3);
        acc    = paying && (sum > 0) && (m_total + sum <= 127);
        m_rej  = (sum > 0) && !acc;
        m_item = '0;
        m_coin = '0;
        nt     = acc ? m_total + sum : m_total;
        case (m_state)
            1: begin
                pick = -1;
                for (int i = 3; i >= 0; i--) if (s[i] && m_stock[i] > 0) pick = i;
                if (rs) for (int i = 0; i < 4; i++) m_stock[i] = 5;
                if (pick >= 0) begin
                    m_state = 2; m_price = prices[pick]; m_idx = pick; m_idle = 0;
                end
            end
            2: begin
                m_total = nt;
                m_idle  = acc ? 0 : m_idle + 1;
                if (cn) begin start_pay(nt); m_state = 5; end
                else if (nt >= m_price) m_state = 3;
                else if (TO_EN && m_idle >= 20) begin start_pay(nt); m_state = 5; end
            end
            3: begin
                m_total = nt;
                if (cn) begin start_pay(nt); m_state = 5; end
                else if (cf) begin
                    m_state = 4;
                    m_item  = 4'(1 << m_idx);
                    if (m_stock[m_idx] > 0) m_stock[m_idx]--;
                    start_pay(nt - m_price);
                end
            end
            4, 5: begin
                m_state = 6;
                if (m_pay.size() > 0) pay_one();
            end
            default: begin
                if (m_pay.size() == 0) begin m_state = 1; m_total = 0; m_price = 0; end
                else pay_one();
            end
        endcase
    endfunction

    function automatic logic [36:0] model_vec();
        logic [3:0] so;
        for (int i = 0; i < 4; i++) so[i] = (m_stock[i] == 0);
        return {3'(m_state), 7'(m_price), 7'(m_total), 7'(m_cl), m_item, m_coin, m_rej,
                so, (m_state == 3)};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare every output.
    task automatic step(input logic [3:0] s, input logic [2:0] c, input logic cf,
                        input logic cn, input logic rs);
        logic [36:0] exp_v, act_v;
        sel = s; coin_in = c; confirm = cf; cancel = cn; restock = rs;
        model_step(s, c, cf, cn, rs);
        @(posedge clk); #1;
        sel = '0; coin_in = '0; confirm = 1'b0; cancel = 1'b0; restock = 1'b0;
        cyc++;
        exp_v = model_vec();
        act_v = {state, price, total, change_left, item_out, coin_out, coin_reject,
                 sold_out, pay_ok};
        tests++;
        if (act_v !== exp_v) begin
            fails++;
            $display("FAIL model cyc %0d (st,pr,tot,cl,item,coin,rej,so,ok): got %h expected %h",
                     cyc, act_v, exp_v);
        end
    endtask

    task automatic idle();
        step(4'b0, 3'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic finish_payout();
        for (int k = 0; k < 40 && m_state != 1; k++) idle();
        chk("payout ends in IDLE", state, 1);
    endtask

    task automatic buy(input int idx, input int n10, input int n5);
        step(4'(1 << idx), 3'b0, 1'b0, 1'b0, 1'b0);
        repeat (n10) step(4'b0, 3'b100, 1'b0, 1'b0, 1'b0);
        repeat (n5) step(4'b0, 3'b010, 1'b0, 1'b0, 1'b0);
        step(4'b0, 3'b0, 1'b1, 1'b0, 1'b0);
        finish_payout();
    endtask

    typedef struct packed {
        logic [3:0] s;
        logic [2:0] c;
        logic       cf;
        logic       cn;
        int         st;
        int         pr;
        int         tot;
        int         cl;
        logic [3:0] it;
        logic [2:0] co;
        logic       rj;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n10, n5, n1, prev, txn;
        logic [31:0] exp_t, act_t;

        // Purchase of item 1, refund of item 0, then a coin in IDLE.
        tbl[0]  = '{4'b0010, 3'b000, 1'b0, 1'b0, 2, 14, 0,  0, 4'b0000, 3'b000, 1'b0};
        tbl[1]  = '{4'b0000, 3'b100, 1'b0, 1'b0, 2, 14, 10, 0, 4'b0000, 3'b000, 1'b0};
        tbl[2]  = '{4'b0000, 3'b010, 1'b0, 1'b0, 3, 14, 15, 0, 4'b0000, 3'b000, 1'b0};
        tbl[3]  = '{4'b0000, 3'b000, 1'b1, 1'b0, 4, 14, 15, 1, 4'b0010, 3'b000, 1'b0};
        tbl[4]  = '{4'b0000, 3'b000, 1'b0, 1'b0, 6, 14, 15, 0, 4'b0000, 3'b001, 1'b0};
        tbl[5]  = '{4'b0000, 3'b000, 1'b0, 1'b0, 1, 0,  0,  0, 4'b0000, 3'b000, 1'b0};
        tbl[6]  = '{4'b0001, 3'b000, 1'b0, 1'b0, 2, 10, 0,  0, 4'b0000, 3'b000, 1'b0};
        tbl[7]  = '{4'b0000, 3'b010, 1'b0, 1'b0, 2, 10, 5,  0, 4'b0000, 3'b000, 1'b0};
        tbl[8]  = '{4'b0000, 3'b001, 1'b0, 1'b0, 2, 10, 6,  0, 4'b0000, 3'b000, 1'b0};
        tbl[9]  = '{4'b0000, 3'b000, 1'b0, 1'b1, 5, 10, 6,  6, 4'b0000, 3'b000, 1'b0};
        tbl[10] = '{4'b0000, 3'b000, 1'b0, 1'b0, 6, 10, 6,  1, 4'b0000, 3'b010, 1'b0};
        tbl[11] = '{4'b0000, 3'b000, 1'b0, 1'b0, 6, 10, 6,  0, 4'b0000, 3'b001, 1'b0};
        tbl[12] = '{4'b0000, 3'b000, 1'b0, 1'b0, 1, 0,  0,  0, 4'b0000, 3'b000, 1'b0};
        tbl[13] = '{4'b0000, 3'b100, 1'b0, 1'b0, 1, 0,  0,  0, 4'b0000, 3'b000, 1'b1};

        // Reset state.
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset state", state, 1);
        chk("reset total", total, 0);
        chk("reset sold_out", sold_out, 0);
        chk("reset pay_ok", pay_ok, 0);
        KEY = 1'b1;

        // Vector table.
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].s, tbl[i].c, tbl[i].cf, tbl[i].cn, 1'b0);
            exp_t = {3'(tbl[i].st), 7'(tbl[i].pr), 7'(tbl[i].tot), 7'(tbl[i].cl),
                     tbl[i].it, tbl[i].co, tbl[i].rj};
            act_t = {state, price, total, change_left, item_out, coin_out, coin_reject};
            tests++;
            if (act_t !== exp_t) begin
                fails++;
                $display("FAIL vec %0d: got %h expected %h", i, act_t, exp_t);
            end
            $display("[TB] vec %0d st=%0d tot=%0d cl=%0d coin=%b", i, state, total,
                     change_left, coin_out);
        end

        // Sell item 3 out, confirm that select is ignored, then restock.
        for (int k = 0; k < 5; k++) begin
            buy(3, 2, 1);
            $display("[TB] bought item 3 (%0d of 5)", k + 1);
        end
        chk("sold_out[3] after 5 buys", sold_out[3], 1);
        step(4'b1000, 3'b0, 1'b0, 1'b0, 1'b0);
        chk("sel on sold-out item", state, 1);
        step(4'b0, 3'b0, 1'b0, 1'b0, 1'b1);
        chk("sold_out after restock", sold_out, 0);

        // Overflow rejection at 126 and a long payout of 101.
        step(4'b1000, 3'b0, 1'b0, 1'b0, 1'b0);
        repeat (9) step(4'b0, 3'b100, 1'b0, 1'b0, 1'b0);
        chk("total after nine 10s", total, 90);
        repeat (3) step(4'b0, 3'b100, 1'b0, 1'b0, 1'b0);
        step(4'b0, 3'b010, 1'b0, 1'b0, 1'b0);
        step(4'b0, 3'b001, 1'b0, 1'b0, 1'b0);
        chk("total at 126", total, 126);
        step(4'b0, 3'b100, 1'b0, 1'b0, 1'b0);
        chk("overflow coin_reject", coin_reject, 1);
        chk("overflow total held", total, 126);
        step(4'b0, 3'b0, 1'b1, 1'b0, 1'b0);
        chk("change owed 101", change_left, 101);
        chk("item_out item 3", item_out, 8);
        n10 = 0; n5 = 0; n1 = 0;
        for (int k = 0; k < 30 && m_state != 1; k++) begin
            idle();
            n10 += coin_out[2]; n5 += coin_out[1]; n1 += coin_out[0];
        end
        chk("payout 10-jiao count", n10, 10);
        chk("payout 5-jiao count", n5, 0);
        chk("payout 1-jiao count", n1, 1);
        $display("[TB] overflow purchase paid %0d x10 %0d x1", n10, n1);

        // Reset during CHANGE with 15 owed, while item 2 has just sold out.
        for (int k = 0; k < 4; k++) buy(2, 2, 0);
        step(4'b0100, 3'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) step(4'b0, 3'b100, 1'b0, 1'b0, 1'b0);
        step(4'b0, 3'b010, 1'b0, 1'b0, 1'b0);
        step(4'b0, 3'b0, 1'b1, 1'b0, 1'b0);
        chk("sold_out[2] after last unit", sold_out[2], 1);
        idle();
        chk("change_left before reset", change_left, 15);
        @(negedge clk);
        KEY = 1'b0;
        #1;
        chk("reset mid-change state", state, 1);
        chk("reset mid-change change_left", change_left, 0);
        chk("reset mid-change total", total, 0);
        chk("reset mid-change price", price, 0);
        chk("reset mid-change outputs", {item_out, coin_out, coin_reject, pay_ok}, 0);
        chk("reset restores stock", sold_out, 0);
        $display("[TB] reset during change");
        model_reset();
        @(negedge clk);
        KEY = 1'b1;
        @(posedge clk); #1;

`ifdef VENDOR_TIMEOUT_EN
        // Timeout: no coin for 20 cycles in PAY forces a refund.
        step(4'b0001, 3'b0, 1'b0, 1'b0, 1'b0);
        step(4'b0, 3'b010, 1'b0, 1'b0, 1'b0);
        repeat (19) idle();
        chk("still PAY before timeout", state, 2);
        idle();
        chk("timeout REFUND", state, 5);
        idle();
        chk("timeout refund coin", coin_out, 2);
        finish_payout();
        $display("[TB] timeout refund");
`endif

        // Random phase against the model.
        txn = 0;
        for (int k = 0; k < 3000; k++) begin
            logic [3:0] rs_sel;
            logic [2:0] rs_coin;
            rs_sel  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
            rs_coin = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b0;
            prev = m_state;
            step(rs_sel, rs_coin, ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 24) == 0), ($urandom_range(0, 29) == 0));
            if (prev == 6 && m_state == 1) begin
                txn++;
                $display("[TB] random txn %0d complete at cycle %0d", txn, cyc);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
